// File: rtl/uart_tx_queue_if.sv
// Producer / transmitter handshake bundle for uart_tx_queue.
// UART_TXQ_OVERFLOW_EN adds the sticky overflow flag and its clear.
interface uart_tx_queue_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_valid;
    logic [7:0]            wr_data;
    logic                  wr_ready;
    logic                  send_start;
    logic [7:0]            send_data;
    logic                  send_busy;
    logic                  send_finish;
    logic [DEPTH_LOG2:0]   level;
    logic                  empty;
    logic                  full;
`ifdef UART_TXQ_OVERFLOW_EN
    logic                  overflow;
    logic                  ovf_clr;

    modport master (
        output wr_valid, wr_data, send_busy, send_finish, ovf_clr,
        input  wr_ready, send_start, send_data, level, empty, full, overflow
    );
    modport slave (
        input  wr_valid, wr_data, send_busy, send_finish, ovf_clr,
        output wr_ready, send_start, send_data, level, empty, full, overflow
    );
`else
    modport master (
        output wr_valid, wr_data, send_busy, send_finish,
        input  wr_ready, send_start, send_data, level, empty, full
    );
    modport slave (
        input  wr_valid, wr_data, send_busy, send_finish,
        output wr_ready, send_start, send_data, level, empty, full
    );
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// Circular byte FIFO feeding a UART transmitter one frame at a time.
// Optional sticky drop flag enabled by defining UART_TXQ_OVERFLOW_EN.
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_queue_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_ZERO = '0;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [DEPTH_LOG2:0]   level, level_nxt;
    logic                  empty_q, full_q, ready_q, start_q;
    logic [7:0]            data_q;
    logic                  wr_acc, pop;

    // wr_ready is registered, so a write can only be accepted while not full.
    assign wr_acc = bus.wr_valid && ready_q;
    assign pop    = (state == IDLE) && !empty_q && !bus.send_busy;

    always_comb begin
        level_nxt = level;
        case ({wr_acc, pop})
            2'b10:   level_nxt = level + LVL_ONE;
            2'b01:   level_nxt = level - LVL_ONE;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc)
            mem[wptr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            start_q <= 1'b0;
            if (wr_acc)
                wptr <= wptr + PTR_ONE;
            case (state)
                IDLE: if (pop) begin
                    data_q  <= mem[rptr];
                    start_q <= 1'b1;
                    rptr    <= rptr + PTR_ONE;
                    state   <= WAIT;
                end
                WAIT: if (bus.send_finish)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
            level   <= level_nxt;
            empty_q <= (level_nxt == LVL_ZERO);
            full_q  <= (level_nxt == LVL_FULL);
            ready_q <= (level_nxt != LVL_FULL);
        end
    end

`ifdef UART_TXQ_OVERFLOW_EN
    logic ovf_q;

    // Set has priority so a drop coinciding with a clear is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (bus.wr_valid && full_q)
            ovf_q <= 1'b1;
        else if (bus.ovf_clr)
            ovf_q <= 1'b0;
    end

    assign bus.overflow = ovf_q;
`endif

    assign bus.wr_ready   = ready_q;
    assign bus.send_start = start_q;
    assign bus.send_data  = data_q;
    assign bus.level      = level;
    assign bus.empty      = empty_q;
    assign bus.full       = full_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_uart_tx_queue;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    uart_tx_queue_if #(.DEPTH_LOG2(DL)) bus ();

    uart_tx_queue #(.DEPTH_LOG2(DL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a plain byte queue plus "frame in flight" flag.
    logic [7:0] mq[$];
    bit         m_frame, m_start, m_ready, m_ovf;
    logic [7:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit acc, ovf_set, clr;
        clr = 1'b0;
`ifdef UART_TXQ_OVERFLOW_EN
        clr = bus.ovf_clr;
`endif
        if (!rst_n) begin
            mq.delete();
            m_frame = 0; m_start = 0; m_data = 8'h00; m_ready = 0; m_ovf = 0;
        end else begin
            acc     = bus.wr_valid && m_ready;
            ovf_set = bus.wr_valid && (mq.size() == DEPTH);
            m_start = 0;
            if (!m_frame && mq.size() > 0 && !bus.send_busy) begin
                m_data  = mq.pop_front();
                m_start = 1;
                m_frame = 1;
            end else if (m_frame && bus.send_finish) begin
                m_frame = 0;
            end
            if (acc) mq.push_back(bus.wr_data);
            m_ready = (mq.size() < DEPTH);
            if (ovf_set) m_ovf = 1;
            else if (clr) m_ovf = 0;
        end
    endtask

    task automatic check_all();
        chk("send_start", bus.send_start, m_start);
        chk("send_data",  bus.send_data,  m_data);
        chk("level",      bus.level,      mq.size());
        chk("empty",      bus.empty,      mq.size() == 0);
        chk("full",       bus.full,       mq.size() == DEPTH);
        chk("wr_ready",   bus.wr_ready,   m_ready);
`ifdef UART_TXQ_OVERFLOW_EN
        chk("overflow",   bus.overflow,   m_ovf);
`endif
    endtask

    // Inputs are set between edges; one call = one rising edge + compare.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(input bit r, input bit wv, input logic [7:0] wd, input bit busy, input bit fin);
        rst_n           = r;
        bus.wr_valid    = wv;
        bus.wr_data     = wd;
        bus.send_busy   = busy;
        bus.send_finish = fin;
    endtask

    typedef struct {
        bit         rst_n, wv;
        logic [7:0] wd;
        bit         busy, fin;
        bit         e_start;
        logic [7:0] e_data;
        int         e_level;
        bit         e_empty, e_full, e_ready;
    } vec_t;

    vec_t tbl[10];

    initial begin
        bit found;
        set_in(0, 1, 8'h33, 0, 0);
`ifdef UART_TXQ_OVERFLOW_EN
        bus.ovf_clr = 1'b0;
`endif
        // Reset with writes offered, then a single A5 frame.
        tbl[0] = '{0, 1, 8'h33, 0, 0,  0, 8'h00, 0, 1, 0, 0};
        tbl[1] = '{0, 1, 8'h33, 0, 0,  0, 8'h00, 0, 1, 0, 0};
        tbl[2] = '{0, 1, 8'h33, 0, 0,  0, 8'h00, 0, 1, 0, 0};
        tbl[3] = '{1, 0, 8'h00, 0, 0,  0, 8'h00, 0, 1, 0, 1};
        tbl[4] = '{1, 1, 8'hA5, 0, 0,  0, 8'h00, 1, 0, 0, 1};
        tbl[5] = '{1, 0, 8'h00, 0, 0,  1, 8'hA5, 0, 1, 0, 1};
        tbl[6] = '{1, 0, 8'h00, 1, 0,  0, 8'hA5, 0, 1, 0, 1};
        tbl[7] = '{1, 0, 8'h00, 0, 0,  0, 8'hA5, 0, 1, 0, 1};
        tbl[8] = '{1, 0, 8'h00, 0, 1,  0, 8'hA5, 0, 1, 0, 1};
        tbl[9] = '{1, 0, 8'h00, 0, 0,  0, 8'hA5, 0, 1, 0, 1};
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].rst_n, tbl[i].wv, tbl[i].wd, tbl[i].busy, tbl[i].fin);
            step();
            chk($sformatf("tbl%0d_start", i), bus.send_start, tbl[i].e_start);
            chk($sformatf("tbl%0d_data", i),  bus.send_data,  tbl[i].e_data);
            chk($sformatf("tbl%0d_level", i), bus.level,      tbl[i].e_level);
            chk($sformatf("tbl%0d_empty", i), bus.empty,      tbl[i].e_empty);
            chk($sformatf("tbl%0d_full", i),  bus.full,       tbl[i].e_full);
            chk($sformatf("tbl%0d_ready", i), bus.wr_ready,   tbl[i].e_ready);
        end

        // Fill behind a busy transmitter, drop a 17th byte, drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 1, 8'(i), 1, 0);
            step();
        end
        set_in(1, 1, 8'hFF, 1, 0);
        step();
        set_in(1, 0, 8'h00, 1, 0);
        step();
        chk("fill_level", bus.level, DEPTH);
        chk("fill_full",  bus.full,  1);
        for (int f = 0; f < DEPTH; f++) begin
            set_in(1, 0, 8'h00, 0, 0);
            found = 0;
            for (int t = 0; t < 6 && !found; t++) begin
                step();
                if (bus.send_start) found = 1;
            end
            chk("fill_launch_seen", found, 1);
            chk("fill_order", bus.send_data, f);
            set_in(1, 0, 8'h00, 0, 1);
            step();
        end
        set_in(1, 0, 8'h00, 0, 0);
        step();
        step();
        chk("drain_level", bus.level, 0);
        chk("drain_no_ff", bus.send_start, 0);

        // Write lands in the same cycle the single queued byte is launched.
        set_in(1, 1, 8'h11, 1, 0);
        step();
        set_in(1, 1, 8'h22, 0, 0);
        step();
        chk("simul_start", bus.send_start, 1);
        chk("simul_data",  bus.send_data,  8'h11);
        chk("simul_level", bus.level,      1);
        set_in(1, 0, 8'h00, 1, 0);
        step();
        set_in(1, 0, 8'h00, 1, 1);
        step();
        set_in(1, 0, 8'h00, 0, 0);
        step();
        chk("simul_next_start", bus.send_start, 1);
        chk("simul_next_data",  bus.send_data,  8'h22);
        set_in(1, 0, 8'h00, 0, 1);
        step();

        // Reset while a frame is in WAIT, then a stale finish.
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 8'h40 + 8'(i), 1, 0);
            step();
        end
        set_in(1, 0, 8'h00, 0, 0);
        step();
        chk("rstmid_launch", bus.send_start, 1);
        chk("rstmid_level3", bus.level, 3);
        set_in(0, 0, 8'h00, 0, 0);
        step();
        set_in(1, 0, 8'h00, 0, 0);
        step();
        chk("rstmid_level0", bus.level, 0);
        chk("rstmid_empty",  bus.empty, 1);
        set_in(1, 0, 8'h00, 0, 1);
        step();
        set_in(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstmid_no_start", bus.send_start, 0);
        end

`ifdef UART_TXQ_OVERFLOW_EN
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 1, 8'(i), 1, 0);
            step();
        end
        chk("ovf_pre", bus.overflow, 0);
        set_in(1, 1, 8'hEE, 1, 0);
        step();
        chk("ovf_set", bus.overflow, 1);
        set_in(1, 0, 8'h00, 1, 0);
        bus.ovf_clr = 1'b1;
        step();
        chk("ovf_clr", bus.overflow, 0);
        set_in(1, 1, 8'hEE, 1, 0);
        step();
        chk("ovf_set_wins", bus.overflow, 1);
        bus.ovf_clr = 1'b0;
`endif

        // Randomized traffic, including stray finishes and rare resets.
        for (int c = 0; c < 3000; c++) begin
            set_in($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1, 8'($urandom),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
`ifdef UART_TXQ_OVERFLOW_EN
            bus.ovf_clr = ($urandom_range(0, 7) == 0);
`endif
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte-wide transmit queue that sits directly upstream of the UART transmit path. It buffers bytes from a producer in a circular FIFO and launches them one at a time through a `send_start`/`send_data` pulse. It paces launches with the transmitter's `send_busy`/`send_finish` handshake, so software or upstream logic can burst bytes without waiting per character.

## Interface
- `DEPTH_LOG2`, default 4: queue depth is 2^DEPTH_LOG2 entries; legal range 1..8.
- `clk` in 1: system clock; all logic rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `wr_valid` in 1: producer offers `wr_data` this cycle.
- `wr_data` in 8: byte to enqueue.
- `wr_ready` out 1: queue can accept; equals `!full`.
- `send_start` out 1: one-cycle launch pulse to transmitter.
- `send_data` out 8: byte being transmitted; stable from launch until finish.
- `send_busy` in 1: transmitter frame in progress.
- `send_finish` in 1: one-cycle pulse, transmitter frame complete.
- `level` out DEPTH_LOG2+1: entries currently stored, 0..2^DEPTH_LOG2.
- `empty` out 1: `level == 0`.
- `full` out 1: `level == 2^DEPTH_LOG2`.
- `overflow` out 1: sticky drop flag; present only with `UART_TXQ_OVERFLOW_EN`.
- `ovf_clr` in 1: clears `overflow`; present only with `UART_TXQ_OVERFLOW_EN`.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 register array, write pointer and read pointer of DEPTH_LOG2 bits each, wrapping modulo depth.
- `level` is a DEPTH_LOG2+1 bit counter. Full and empty are derived from `level`, not from pointer compare.
- Write accepted when `wr_valid && wr_ready` at a rising edge. Data goes into `mem[wptr]`, `wptr`+1, `level`+1.
- Write while full: ignored, and storage is not modified.
- FSM states:
  - IDLE: if `!empty && !send_busy`, pop head into the `send_data` register, assert `send_start`, decrement `level`, advance `rptr`, go to WAIT.
  - WAIT: hold `send_data`. On `send_finish`, go to IDLE. `send_busy` is ignored in WAIT.
- `send_finish` in IDLE is ignored.
- Simultaneous accepted write and pop in one cycle: `level` unchanged, both pointers advance.
- Pop from a queue holding one entry while a write arrives: the popped byte is the old head, and the new byte remains queued.
- Reset mid-frame: FSM returns to IDLE, queue is emptied, and no `send_start` is issued until the next launch condition. Any frame already in flight downstream is not affected by this block.

## Timing
- Reset values:
  - `wr_ready`=0 during reset, 1 from the first cycle after release.
  - `send_start`=0, `send_data`=8'h00, `level`=0, `empty`=1, `full`=0, `overflow`=0.
  - Pointers 0, FSM in IDLE.
- `level`, `empty`, `full`, `wr_ready` are registered-derived and update the cycle after the accepting or popping edge.
- Latency: byte accepted at edge k into an empty queue with transmitter idle gives `send_start` high during cycle k+1..k+2 (asserted by edge k+1). `send_data` is valid in the same cycle.
- `send_start` is exactly one cycle wide.
- Back-to-back frames:
  - `send_finish` sampled at edge f returns the FSM to IDLE.
  - The next `send_start` is asserted by edge f+1 if the queue is non-empty and `send_busy` is low.
  - Minimum one idle cycle between frames.
- Throughput: one byte per transmitter frame; queue accepts one byte per cycle.

## Configuration
- `UART_TXQ_OVERFLOW_EN` defined:
  - `overflow` and `ovf_clr` ports exist.
  - `overflow` sets at the edge after any cycle with `wr_valid && full`, and stays set until `ovf_clr` is sampled high.
  - Set wins over a simultaneous clear.
- `UART_TXQ_OVERFLOW_EN` undefined: both ports and the flag logic are absent. Writes while full are silently dropped.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `wr_valid`=1 -> after release `level`=0, `empty`=1, `send_start`=0, no byte stored.
- Single byte: write 8'hA5 with transmitter idle -> one `send_start` pulse, `send_data`=8'hA5, held until `send_finish`, `level` returns 0.
- Fill: with `send_busy` forced high, write 8'h00..8'h0F (DEPTH_LOG2=4) -> `full`=1, `level`=16. A 17th write of 8'hFF is dropped. After releasing `send_busy` and pulsing `send_finish` per frame, bytes 8'h00..8'h0F emerge in order and 8'hFF never appears.
- Simultaneous: with `level`=1 and head 8'h11, write 8'h22 in the cycle the FSM launches -> `send_data`=8'h11, `level` stays 1, next launch sends 8'h22.
- Reset mid-operation: 4 bytes queued, reset during WAIT -> `level`=0, FSM IDLE, a late `send_finish` after release causes no `send_start`.
- Overflow (`UART_TXQ_OVERFLOW_EN`): write while full -> `overflow`=1 next cycle. `ovf_clr` pulse -> 0. Clear coincident with a new full write -> stays 1.
